// File: rtl/spi_ram_arbiter_if.sv
// Local requester port of the SPI RAM arbiter.
// master = requester, slave = arbiter.
interface spi_ram_arbiter_if #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8
);
  logic                 loc_req;
  logic                 loc_we;
  logic [ADDR_SIZE-1:0] loc_addr;
  logic [MEM_WIDTH-1:0] loc_wdata;
  logic                 loc_gnt;
  logic [MEM_WIDTH-1:0] loc_rdata;
  logic                 loc_rvalid;

  modport master (
    output loc_req, loc_we, loc_addr, loc_wdata,
    input  loc_gnt, loc_rdata, loc_rvalid
  );

  modport slave (
    input  loc_req, loc_we, loc_addr, loc_wdata,
    output loc_gnt, loc_rdata, loc_rvalid
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// SPI command decoder plus round-robin arbiter between
// the SPI path and a local requester on one sync RAM.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8,
  parameter int TX_HOLD   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  spi_ram_arbiter_if.slave     loc,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0] mem_wdata,
  input  logic [MEM_WIDTH-1:0] mem_rdata,
  output logic                 ovf_err
);
  localparam int CW = $clog2(TX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_CAP
  } state_e;

  state_e               state_q;
  logic [ADDR_SIZE-1:0] wr_addr_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  logic                 pend_q;
  logic                 pend_we_q;
  logic [ADDR_SIZE-1:0] pend_addr_q;
  logic [MEM_WIDTH-1:0] pend_data_q;
  logic                 last_spi_q;
  logic                 rd_spi_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q;
  logic [MEM_WIDTH-1:0] loc_rdata_q;
  logic                 loc_rvalid_q;
  logic                 ovf_q;

  logic idle;
  logic grant_spi;
  logic grant_loc;
  logic spi_cmd;

  // Issue is combinational so an SPI op can hit the RAM one cycle after rx_valid.
  assign idle      = (state_q == IDLE) && !rst;
  assign grant_spi = idle && pend_q && (!loc.loc_req || !last_spi_q);
  assign grant_loc = idle && loc.loc_req && !grant_spi;
  assign spi_cmd   = rx_valid && rx_data[8];

  always_comb begin
    mem_en    = grant_spi | grant_loc;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      grant_spi: begin
        mem_we    = pend_we_q;
        mem_addr  = pend_addr_q;
        mem_wdata = pend_data_q;
      end
      grant_loc: begin
        mem_we    = loc.loc_we;
        mem_addr  = loc.loc_addr;
        mem_wdata = loc.loc_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      last_spi_q   <= 1'b0;
      rd_spi_q     <= 1'b0;
      tx_cnt_q     <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      loc_rdata_q  <= '0;
      loc_rvalid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      loc_rvalid_q <= 1'b0;
      if (rx_valid) begin
        unique case (rx_data[9:8])
          2'b00:   wr_addr_q <= ADDR_SIZE'(rx_data[7:0]);
          2'b10:   rd_addr_q <= ADDR_SIZE'(rx_data[7:0]);
          default: ;
        endcase
      end
      if (grant_spi) pend_q <= 1'b0;
      // Refill in the issue cycle is legal; only a still-waiting op overflows.
      if (spi_cmd) begin
        if (pend_q && !grant_spi) begin
          ovf_q <= 1'b1;
        end else begin
          pend_q      <= 1'b1;
          pend_we_q   <= !rx_data[9];
          pend_addr_q <= rx_data[9] ? rd_addr_q : wr_addr_q;
          pend_data_q <= MEM_WIDTH'(rx_data[7:0]);
        end
      end
      if (mem_en) last_spi_q <= grant_spi;
      if (tx_valid_q) begin
        if (tx_cnt_q == '0) tx_valid_q <= 1'b0;
        else                tx_cnt_q   <= tx_cnt_q - CW'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (mem_en && !mem_we) begin
            state_q  <= RD_WAIT;
            rd_spi_q <= grant_spi;
          end
        end
        RD_WAIT: begin
          state_q <= RD_CAP;
          if (rd_spi_q) begin
            tx_data_q  <= 8'(mem_rdata);
            tx_valid_q <= 1'b1;
            tx_cnt_q   <= CW'(TX_HOLD - 1);
          end else begin
            loc_rdata_q  <= mem_rdata;
            loc_rvalid_q <= 1'b1;
          end
        end
        RD_CAP:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign ovf_err        = ovf_q;
  assign loc.loc_gnt    = grant_loc;
  assign loc.loc_rdata  = loc_rdata_q;
  assign loc.loc_rvalid = loc_rvalid_q;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter with a
// behavioural single-port RAM behind it.
module tb_spi_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       ovf_err;

  always #5 clk = ~clk;

  spi_ram_arbiter_if #(.ADDR_SIZE(8), .MEM_WIDTH(8)) lif ();

  spi_ram_arbiter #(
    .ADDR_SIZE(8),
    .MEM_WIDTH(8),
    .TX_HOLD(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .loc      (lif),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .ovf_err  (ovf_err)
  );

  typedef struct {
    bit         loc;
    bit         we;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } mexp_t;

  mexp_t      exp_mem[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_loc[$];
  logic [7:0] ref_mem[256];
  logic [7:0] ram[256];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_frame(input logic [9:0] f, input bit timed,
                           input bit push);
    mexp_t e;
    int c;
    rx_data  = f;
    rx_valid = 1'b1;
    c = cyc;
    case (f[9:8])
      2'd0: m_wr = f[7:0];
      2'd2: m_rd = f[7:0];
      2'd1: if (push) begin
        e = '{loc: 1'b0, we: 1'b1, addr: m_wr, data: f[7:0],
              cyc: (timed ? c + 1 : 0)};
        exp_mem.push_back(e);
        ref_mem[m_wr] = f[7:0];
      end
      default: if (push) begin
        e = '{loc: 1'b0, we: 1'b0, addr: m_rd, data: 8'h00,
              cyc: (timed ? c + 1 : 0)};
        exp_mem.push_back(e);
        exp_tx.push_back(ref_mem[m_rd]);
      end
    endcase
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic loc_access(input bit we, input logic [7:0] a,
                            input logic [7:0] d);
    mexp_t e;
    bit got = 1'b0;
    lif.loc_req   = 1'b1;
    lif.loc_we    = we;
    lif.loc_addr  = a;
    lif.loc_wdata = d;
    e = '{loc: 1'b1, we: we, addr: a, data: d, cyc: 0};
    exp_mem.push_back(e);
    if (we) ref_mem[a] = d;
    else    exp_loc.push_back(ref_mem[a]);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = lif.loc_gnt;
    end
    if (!got) chk("loc_gnt_timeout", lif.loc_gnt, 1);
    tick();
    lif.loc_req = 1'b0;
  endtask

  int         rd_issue = -100;
  int         tx_run = 0;
  bit         tx_prev = 1'b0;
  logic [7:0] tx_last = '0;

  always @(negedge clk) begin
    mexp_t e;
    logic [7:0] v;
    if (mem_en) begin
      if (exp_mem.size() == 0) begin
        chk("mem_unexp", mem_en, 0);
      end else begin
        e = exp_mem.pop_front();
        chk("mem_src", lif.loc_gnt, e.loc);
        chk("mem_we", mem_we, e.we);
        chk("mem_addr", mem_addr, e.addr);
        if (e.we) chk("mem_wdata", mem_wdata, e.data);
        if (e.cyc != 0) chk("mem_cyc", cyc, e.cyc);
      end
      if (!mem_we) rd_issue = cyc;
    end
    if (lif.loc_rvalid) begin
      if (exp_loc.size() == 0) begin
        chk("rv_unexp", lif.loc_rvalid, 0);
      end else begin
        v = exp_loc.pop_front();
        chk("loc_rdata", lif.loc_rdata, v);
      end
      chk("rv_lat", cyc, rd_issue + 2);
    end
    if (tx_valid && !tx_prev) begin
      if (exp_tx.size() == 0) begin
        chk("tx_unexp", tx_valid, 0);
      end else begin
        v = exp_tx.pop_front();
        chk("tx_data", tx_data, v);
        tx_last = v;
      end
      chk("tx_lat", cyc, rd_issue + 2);
    end
    if (tx_valid) begin
      tx_run++;
    end else if (tx_prev) begin
      chk("tx_hold", tx_run, 8);
      chk("tx_keep", tx_data, tx_last);
      tx_run = 0;
    end
    tx_prev = tx_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mexp_t e;
    rx_data       = '0;
    rx_valid      = 1'b0;
    lif.loc_req   = 1'b0;
    lif.loc_we    = 1'b0;
    lif.loc_addr  = '0;
    lif.loc_wdata = '0;
    m_wr = '0;
    m_rd = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      ram[i]     = '0;
    end

    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_gnt", lif.loc_gnt, 0);
    chk("rst_rvalid", lif.loc_rvalid, 0);
    chk("rst_rdata", lif.loc_rdata, 0);
    tick();
    rst = 1'b0;

    // SPI wins the first conflict, local the next
    spi_frame(10'h177, 1'b1, 1'b1);
    lif.loc_req   = 1'b1;
    lif.loc_we    = 1'b1;
    lif.loc_addr  = 8'h20;
    lif.loc_wdata = 8'h11;
    e = '{loc: 1'b1, we: 1'b1, addr: 8'h20, data: 8'h11, cyc: cyc + 1};
    exp_mem.push_back(e);
    ref_mem[8'h20] = 8'h11;
    spi_frame(10'h178, 1'b0, 1'b1);
    tick();
    lif.loc_req = 1'b0;
    repeat (3) tick();

    spi_frame(10'h0C5, 1'b1, 1'b1);
    spi_frame(10'h153, 1'b1, 1'b1);
    repeat (2) tick();
    spi_frame(10'h2C5, 1'b1, 1'b1);
    spi_frame(10'h3E7, 1'b1, 1'b1);
    repeat (12) tick();
    chk("ovf_clear", ovf_err, 0);

    loc_access(1'b1, 8'h10, 8'hAA);
    loc_access(1'b0, 8'h10, 8'h00);
    repeat (4) tick();
    spi_frame(10'h220, 1'b1, 1'b1);
    spi_frame(10'h300, 1'b1, 1'b1);
    repeat (12) tick();

    // second write frame arrives while the first is still pending
    spi_frame(10'h040, 1'b1, 1'b1);
    lif.loc_req  = 1'b1;
    lif.loc_we   = 1'b0;
    lif.loc_addr = 8'h10;
    e = '{loc: 1'b1, we: 1'b0, addr: 8'h10, data: 8'h00, cyc: cyc};
    exp_mem.push_back(e);
    exp_loc.push_back(ref_mem[8'h10]);
    spi_frame(10'h1A5, 1'b0, 1'b1);
    lif.loc_req = 1'b0;
    spi_frame(10'h15A, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_set", ovf_err, 1);
    repeat (3) tick();
    spi_frame(10'h240, 1'b1, 1'b1);
    spi_frame(10'h300, 1'b1, 1'b1);
    repeat (12) tick();
    chk("ovf_sticky", ovf_err, 1);

    // reset while the local read sits in RD_WAIT
    lif.loc_req  = 1'b1;
    lif.loc_we   = 1'b0;
    lif.loc_addr = 8'h10;
    e = '{loc: 1'b1, we: 1'b0, addr: 8'h10, data: 8'h00, cyc: cyc};
    exp_mem.push_back(e);
    tick();
    lif.loc_req = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst2_mem_en", mem_en, 0);
    chk("rst2_rvalid", lif.loc_rvalid, 0);
    chk("rst2_rdata", lif.loc_rdata, 0);
    chk("rst2_tx_valid", tx_valid, 0);
    chk("rst2_tx_data", tx_data, 0);
    chk("rst2_ovf", ovf_err, 0);
    tick();
    rst  = 1'b0;
    m_wr = '0;
    m_rd = '0;
    repeat (6) tick();

    chk("mem_q_left", exp_mem.size(), 0);
    chk("tx_q_left", exp_tx.size(), 0);
    chk("loc_q_left", exp_loc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave's RAM-side interface (rx_data/rx_valid, tx_data/tx_valid) and one single-port synchronous RAM.
- Decodes SPI command frames and holds the write and read address registers.
- Arbitrates RAM access round-robin between the SPI path and a local requester port.
- Returns SPI read data to the slave with the hold timing the slave needs to serialize it onto MISO.

Parameters:
- ADDR_SIZE, 8, RAM address width (depth 2**ADDR_SIZE).
- MEM_WIDTH, 8, RAM data width; must be 8 (SPI payload and tx_data are 8 bits).
- TX_HOLD, 8, cycles tx_valid/tx_data are held after an SPI read completes.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  10  SPI frame: [9:8] = command, [7:0] = payload.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  out  8  read data toward the SPI slave.
- tx_valid  out  1  tx_data valid, held TX_HOLD cycles.
- loc_req  in  1  local access request; level, held until loc_gnt.
- loc_we  in  1  1 = write, 0 = read; stable while loc_req.
- loc_addr  in  ADDR_SIZE  local address.
- loc_wdata  in  MEM_WIDTH  local write data.
- loc_gnt  out  1  one-cycle pulse in the cycle the local access is issued.
- loc_rdata  out  MEM_WIDTH  local read data.
- loc_rvalid  out  1  one-cycle pulse; loc_rdata valid.
- mem_en, mem_we  out  1  RAM enable and write enable.
- mem_addr  out  ADDR_SIZE  RAM address.
- mem_wdata  out  MEM_WIDTH  RAM write data.
- mem_rdata  in  MEM_WIDTH  RAM read data, valid the cycle after mem_en with mem_we=0.
- ovf_err  out  1  sticky: an SPI access command was dropped.

Behaviour:
- Reset: every output is 0, both address registers are 0, the pending slot is cleared, FSM = IDLE, the round-robin pointer selects SPI first, and the TX counter is 0. Reset mid-operation abandons any in-flight read; no rvalid or tx_valid is produced for it.
- Command decode, on the edge where rx_valid=1:
  - 00: wr_addr <= payload.
  - 01: SPI write pending, using the current wr_addr and payload.
  - 10: rd_addr <= payload.
  - 11: SPI read pending, using the current rd_addr; the payload is ignored.
- The pending op snapshots its address at command time. Later 00/10 commands update the address registers only.
- A 01 or 11 arriving while an SPI op is still pending (not yet issued) is dropped and sets ovf_err. The existing pending op is unaffected.
- FSM states: IDLE, RD_WAIT, RD_CAP.
  - IDLE: if any requester is pending, issue exactly one access (mem_en=1) this cycle.
  - Grant choice when both SPI and local are pending: the requester not served last wins. Otherwise the sole requester wins.
  - Write: mem_we=1; stay in IDLE, so back-to-back writes are allowed.
  - Read: mem_we=0; go to RD_WAIT.
  - RD_WAIT: mem_rdata is valid; register it and go to RD_CAP.
  - RD_CAP: deliver the registered data (see read latency below), then return to IDLE.
  - mem_en=0 in RD_WAIT and RD_CAP; no grants are issued there.
- A local grant drives loc_gnt=1 in the issue cycle. The requester may change its fields or drop loc_req from the next cycle.
- Read latency: mem_en issued in cycle N gives loc_rvalid=1 (local) or tx_valid rising (SPI) in cycle N+2.
- SPI write latency: rx_valid in cycle R gives mem_en in cycle R+1 at the earliest.
- TX: on SPI read delivery, tx_data <= data and tx_valid=1 for exactly TX_HOLD cycles, then 0. tx_data holds its value after that.
  - A new SPI read delivered during an active hold replaces tx_data and restarts the count.
- rx_valid and the local access issue may fall in the same cycle; both take effect. A new SPI pending op may be set in the same cycle the previous one is issued; this is not overflow.
- Address arithmetic is plain; no auto-increment and no wrap logic.

Test Plan:
- Frames 0x0C5 (00, addr C5), then 0x153 (01, data 53), no local traffic -> one cycle with mem_en=1, mem_we=1, mem_addr=C5, mem_wdata=53, issued one cycle after the second rx_valid.
- After the previous scenario, frames 0x2C5 (10, addr C5), then 0x3xx (11) -> mem read of C5; tx_data=53 with tx_valid=1 from issue+2 for exactly 8 cycles; ovf_err=0.
- Local write to 0x10 with data 0xAA, then local read of 0x10 -> loc_gnt pulse for each; loc_rvalid pulse 2 cycles after the read gnt with loc_rdata=AA.
- SPI write pending and loc_req both present in the same IDLE cycle straight after reset -> SPI is issued first. Local is issued the next cycle. On the next conflict, local wins.
- Two 01 frames, with local continuous reads keeping the FSM busy so the first is not yet issued -> second frame dropped, ovf_err=1 until rst, first write lands intact.
- rst asserted in RD_WAIT -> all outputs 0 next cycle; no loc_rvalid or tx_valid for the abandoned read.
